// File: rtl/dct_array_sequencer.sv
// Sequencer for the 4-point 1-D DCT systolic array: captures a sample vector, drives the
// skewed north/west schedule from a Q8 coefficient ROM, waits for done and returns descaled outputs.
module dct_array_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [31:0] s_x0,
  input  logic signed [31:0] s_x1,
  input  logic signed [31:0] s_x2,
  input  logic signed [31:0] s_x3,
  output logic               arr_clr,
  output logic signed [31:0] in_north0,
  output logic signed [31:0] in_west0,
  output logic signed [31:0] in_west1,
  output logic signed [31:0] in_west2,
  output logic signed [31:0] in_west3,
  input  logic signed [63:0] result0,
  input  logic signed [63:0] result1,
  input  logic signed [63:0] result2,
  input  logic signed [63:0] result3,
  input  logic               done,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [31:0] m_y0,
  output logic signed [31:0] m_y1,
  output logic signed [31:0] m_y2,
  output logic signed [31:0] m_y3,
  output logic               m_sat,
  output logic               err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_OUT} state_t;

  state_t             state_q;
  logic [2:0]         k_q;
  logic [CW-1:0]      cnt_q;
  logic               s_ready_q, arr_clr_q, m_valid_q, m_sat_q, err_q;
  logic signed [31:0] north_q;
  logic signed [31:0] x_q    [4];
  logic signed [31:0] west_q [4];
  logic signed [31:0] y_q    [4];
  logic signed [63:0] res_q  [4];
  logic signed [31:0] y_d    [4];
  logic [32:0]        ds     [4];
  logic               sat_d;

  function automatic logic signed [31:0] coef(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0, 4'h1, 4'h2, 4'h3: coef = 32'sd128;
      4'h4:                   coef = 32'sd167;
      4'h5:                   coef = 32'sd69;
      4'h6:                   coef = -32'sd69;
      4'h7:                   coef = -32'sd167;
      4'h8, 4'hb:             coef = 32'sd128;
      4'h9, 4'ha:             coef = -32'sd128;
      4'hc:                   coef = 32'sd69;
      4'hd:                   coef = -32'sd167;
      4'he:                   coef = 32'sd167;
      default:                coef = -32'sd69;
    endcase
  endfunction

  // Row r lags row 0 by r steps and consumes its coefficient row back to front.
  function automatic logic signed [31:0] feed_west(input int r, input logic [2:0] k);
    int d;
    d = int'(k) - r;
    if (d >= 0 && d <= 3) feed_west = coef(2'(r), 2'(3 - d));
    else                  feed_west = '0;
  endfunction

  // Truncating divide by 256 (bias negatives by 255), then clamp to 32 bits.
  function automatic logic [32:0] descale(input logic signed [63:0] v);
    logic signed [63:0] t;
    t = v[63] ? v + 64'sd255 : v;
    t = t >>> 8;
    if (t > 64'sd2147483647)       descale = {1'b1, 32'h7fff_ffff};
    else if (t < -64'sd2147483648) descale = {1'b1, 32'h8000_0000};
    else                           descale = {1'b0, t[31:0]};
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_descale
      assign ds[gi]  = descale(res_q[gi]);
      assign y_d[gi] = signed'(ds[gi][31:0]);
    end
  endgenerate
  assign sat_d = ds[0][32] | ds[1][32] | ds[2][32] | ds[3][32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      arr_clr_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_sat_q   <= 1'b0;
      err_q     <= 1'b0;
      north_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        x_q[i]    <= '0;
        west_q[i] <= '0;
        y_q[i]    <= '0;
        res_q[i]  <= '0;
      end
    end else begin
      arr_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          s_ready_q <= 1'b1;
          if (s_valid && s_ready_q) begin
            x_q[0]    <= s_x0;
            x_q[1]    <= s_x1;
            x_q[2]    <= s_x2;
            x_q[3]    <= s_x3;
            s_ready_q <= 1'b0;
            state_q   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          arr_clr_q <= 1'b1;
          north_q   <= '0;
          for (int r = 0; r < 4; r++) west_q[r] <= '0;
          k_q       <= '0;
          state_q   <= S_FEED;
        end
        S_FEED: begin
          case (k_q)
            3'd0:    north_q <= x_q[3];
            3'd1:    north_q <= x_q[2];
            3'd2:    north_q <= x_q[1];
            3'd3:    north_q <= x_q[0];
            default: north_q <= '0;
          endcase
          for (int r = 0; r < 4; r++) west_q[r] <= feed_west(r, k_q);
          if (k_q == 3'd6) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        S_WAIT: begin
          north_q <= '0;
          for (int r = 0; r < 4; r++) west_q[r] <= '0;
          if (done) begin
            res_q[0] <= result0;
            res_q[1] <= result1;
            res_q[2] <= result2;
            res_q[3] <= result3;
            state_q  <= S_OUT;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            err_q     <= 1'b1;
            arr_clr_q <= 1'b1;
            s_ready_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_OUT: begin
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
            m_sat_q   <= sat_d;
            for (int i = 0; i < 4; i++) y_q[i] <= y_d[i];
          end else if (m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign arr_clr     = arr_clr_q;
  assign in_north0   = north_q;
  assign in_west0    = west_q[0];
  assign in_west1    = west_q[1];
  assign in_west2    = west_q[2];
  assign in_west3    = west_q[3];
  assign m_valid     = m_valid_q;
  assign m_y0        = y_q[0];
  assign m_y1        = y_q[1];
  assign m_y2        = y_q[2];
  assign m_y3        = y_q[3];
  assign m_sat       = m_sat_q;
  assign err_timeout = err_q;

endmodule
